// File: rtl/seq_detector_n_if.sv
// seq_detector_n_if: serial-stream bundle for seq_detector_n
//   en, clr, x       : sample-valid, synchronous clear, serial bit (master -> slave)
//   y                : Mealy match flag (slave -> master)
//   state            : matched-prefix length 0..N-1
//   match_count, sat : saturating match counter and its sticky overflow flag
interface seq_detector_n_if #(
  parameter int N = 4,
  parameter int CNT_W = 8
);
  localparam int SW = $clog2(N);
  logic en;
  logic clr;
  logic x;
  logic y;
  logic [SW-1:0] state;
  logic [CNT_W-1:0] match_count;
  logic sat;
  modport master (output en, clr, x, input y, state, match_count, sat);
  modport slave (input en, clr, x, output y, state, match_count, sat);
endinterface

// File: rtl/seq_detector_n.sv
// seq_detector_n: parametrised Mealy detector of PATTERN on a serial stream
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : seq_detector_n_if.slave (en, clr, x in; y, state, match_count, sat out)
module seq_detector_n #(
  parameter int N = 4,
  parameter logic [N-1:0] PATTERN = 4'b1101,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W = 8
) (
  input logic clock,
  input logic reset,
  seq_detector_n_if.slave bus
);
  localparam int SW = $clog2(N);
  if (N < 2 || N > 16) begin : g_bad
    $fatal(1, "seq_detector_n: N must be in 2..16");
  end
  typedef enum logic [SW-1:0] {EMPTY = SW'(0), FULL = SW'(N - 1)} state_t;
  // Longest j such that the last j bits of (prefix of length k, then b) equal the
  // first j pattern bits, capped below N so a full match lands on its border F(N).
  function automatic int fb(input int k, input logic b);
    logic [16:0] s;
    logic ok;
    int best;
    s = '0;
    for (int i = 0; i < k; i++) s[i] = PATTERN[N-1-i];
    s[k] = b;
    best = 0;
    for (int j = 1; j <= k + 1 && j < N; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) if (s[k+1-j+i] != PATTERN[N-1-i]) ok = 1'b0;
      if (ok) best = j;
    end
    return best;
  endfunction
  logic [SW-1:0] nxt0 [N];
  logic [SW-1:0] nxt1 [N];
  for (genvar k = 0; k < N; k++) begin : g_fb
    assign nxt0[k] = SW'(fb(k, 1'b0));
    assign nxt1[k] = SW'(fb(k, 1'b1));
  end
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic sat;
  logic hit;
  always_comb begin
    nxt = state;
    hit = 1'b0;
    if (bus.clr) nxt = EMPTY;
    else if (bus.en) begin
      if (int'(state) >= N) nxt = EMPTY;
      else begin
        hit = reset && state == FULL && bus.x == PATTERN[0];
        nxt = hit && !OVERLAP ? EMPTY : state_t'(bus.x ? nxt1[state] : nxt0[state]);
      end
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= bus.clr ? '0 : hit && !(&cnt) ? cnt + 1'b1 : cnt;
      sat <= !bus.clr && (sat || (hit && &cnt));
    end
  end
  assign bus.y = hit;
  assign bus.state = state;
  assign bus.match_count = cnt;
  assign bus.sat = sat;
endmodule

// File: tb/tb_seq_detector_n.sv
// tb_seq_detector_n: six parameterisations on one stream, history model plus directed checks
module tb_seq_detector_n;
  logic clock = 1'b0;
  logic reset, en, clr, x;
  always #5 clock = ~clock;
  logic y_a [6];
  logic [3:0] st_a [6];
  logic [7:0] cnt_a [6];
  logic sat_a [6];
  logic yv [6];
  int n_chk = 0;
  int n_fail = 0;

  seq_detector_n_if #(.N(4), .CNT_W(8)) b0 ();
  seq_detector_n #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) d0 (.clock(clock), .reset(reset), .bus(b0));
  assign b0.en = en; assign b0.clr = clr; assign b0.x = x;
  assign y_a[0] = b0.y; assign st_a[0] = 4'(b0.state); assign cnt_a[0] = 8'(b0.match_count); assign sat_a[0] = b0.sat;

  seq_detector_n_if #(.N(4), .CNT_W(8)) b1 ();
  seq_detector_n #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) d1 (.clock(clock), .reset(reset), .bus(b1));
  assign b1.en = en; assign b1.clr = clr; assign b1.x = x;
  assign y_a[1] = b1.y; assign st_a[1] = 4'(b1.state); assign cnt_a[1] = 8'(b1.match_count); assign sat_a[1] = b1.sat;

  seq_detector_n_if #(.N(4), .CNT_W(8)) b2 ();
  seq_detector_n #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) d2 (.clock(clock), .reset(reset), .bus(b2));
  assign b2.en = en; assign b2.clr = clr; assign b2.x = x;
  assign y_a[2] = b2.y; assign st_a[2] = 4'(b2.state); assign cnt_a[2] = 8'(b2.match_count); assign sat_a[2] = b2.sat;

  seq_detector_n_if #(.N(4), .CNT_W(8)) b3 ();
  seq_detector_n #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b0), .CNT_W(8)) d3 (.clock(clock), .reset(reset), .bus(b3));
  assign b3.en = en; assign b3.clr = clr; assign b3.x = x;
  assign y_a[3] = b3.y; assign st_a[3] = 4'(b3.state); assign cnt_a[3] = 8'(b3.match_count); assign sat_a[3] = b3.sat;

  seq_detector_n_if #(.N(4), .CNT_W(2)) b4 ();
  seq_detector_n #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) d4 (.clock(clock), .reset(reset), .bus(b4));
  assign b4.en = en; assign b4.clr = clr; assign b4.x = x;
  assign y_a[4] = b4.y; assign st_a[4] = 4'(b4.state); assign cnt_a[4] = 8'(b4.match_count); assign sat_a[4] = b4.sat;

  seq_detector_n_if #(.N(5), .CNT_W(8)) b5 ();
  seq_detector_n #(.N(5), .PATTERN(5'b10110), .OVERLAP(1'b1), .CNT_W(8)) d5 (.clock(clock), .reset(reset), .bus(b5));
  assign b5.en = en; assign b5.clr = clr; assign b5.x = x;
  assign y_a[5] = b5.y; assign st_a[5] = 4'(b5.state); assign cnt_a[5] = 8'(b5.match_count); assign sat_a[5] = b5.sat;

  // Model: keep the consumed bits (newest in bit 0) since reset/clr, or since the
  // last match when overlap is off, and read every output off that history.
  int pat [6] = '{13, 13, 15, 15, 13, 22};
  int nn [6] = '{4, 4, 4, 4, 4, 5};
  int ov [6] = '{1, 0, 1, 0, 1, 1};
  int cw [6] = '{8, 8, 8, 8, 2, 8};
  int hist [6];
  int hlen [6];
  int mcnt [6];
  int msat [6];

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  function automatic int msk(input int j);
    return (1 << j) - 1;
  endfunction

  function automatic int m_match(input int i, input logic b);
    int c;
    c = (hist[i] << 1) | int'(b);
    return int'(hlen[i] + 1 >= nn[i] && (c & msk(nn[i])) == pat[i]);
  endfunction

  function automatic int m_state(input int i);
    for (int j = nn[i] - 1; j > 0; j--)
      if (j <= hlen[i] && (hist[i] & msk(j)) == (pat[i] >> (nn[i] - j))) return j;
    return 0;
  endfunction

  task automatic m_clear(input int i);
    hist[i] = 0;
    hlen[i] = 0;
    mcnt[i] = 0;
    msat[i] = 0;
  endtask

  task automatic m_update(input int i);
    int h;
    if (!reset || clr) m_clear(i);
    else if (en) begin
      h = m_match(i, x);
      hist[i] = (hist[i] << 1) | int'(x);
      if (hlen[i] < 32) hlen[i]++;
      if (h != 0) begin
        if (mcnt[i] == (1 << cw[i]) - 1) msat[i] = 1;
        else mcnt[i]++;
        if (ov[i] == 0) begin
          hist[i] = 0;
          hlen[i] = 0;
        end
      end
    end
  endtask

  always @(negedge reset) for (int i = 0; i < 6; i++) m_clear(i);

  initial begin
    for (int i = 0; i < 6; i++) m_clear(i);
    forever begin
      @(negedge clock);
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("model_y%0d", i), int'(y_a[i]), (reset && en && !clr) ? m_match(i, x) : 0);
        chk($sformatf("model_state%0d", i), int'(st_a[i]), m_state(i));
        chk($sformatf("model_count%0d", i), int'(cnt_a[i]), mcnt[i]);
        chk($sformatf("model_sat%0d", i), int'(sat_a[i]), msat[i]);
      end
      @(posedge clock);
      for (int i = 0; i < 6; i++) m_update(i);
    end
  end

  task automatic step(input logic e, input logic c, input logic b);
    en = e;
    clr = c;
    x = b;
    #1;
    for (int i = 0; i < 6; i++) yv[i] = y_a[i];
    @(posedge clock);
    #1;
  endtask

  logic [6:0] bits7;
  logic [6:0] ym0, ym1;
  logic [5:0] ym2, ym3;
  logic [7:0] s1;
  logic [3:0] p4;

  initial begin
    reset = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    x = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("rst_state", int'(st_a[i]), 0);
      chk("rst_count", int'(cnt_a[i]), 0);
      chk("rst_sat", int'(sat_a[i]), 0);
    end
    reset = 1'b1;
    bits7 = 7'b1101101;
    ym0 = '0;
    ym1 = '0;
    s1 = '0;
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 1'b0, bits7[6-k]);
      ym0[k] = yv[0];
      ym1[k] = yv[1];
      if (k >= 3) s1 = {s1[5:0], st_a[1][1:0]};
    end
    chk("ovl_y_bits", int'(ym0), 7'b1001000);
    chk("ovl_count", int'(cnt_a[0]), 2);
    chk("ovl_state", int'(st_a[0]), 1);
    chk("novl_y_bits", int'(ym1), 7'b0001000);
    chk("novl_count", int'(cnt_a[1]), 1);
    chk("novl_states", int'(s1), 8'b00_01_00_01);
    chk("cnt2_count", int'(cnt_a[4]), 2);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("clr_state", int'(st_a[i]), 0);
      chk("clr_count", int'(cnt_a[i]), 0);
    end
    ym2 = '0;
    ym3 = '0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 1'b1);
      ym2[k] = yv[2];
      ym3[k] = yv[3];
    end
    chk("ones_ovl_y", int'(ym2), 6'b111000);
    chk("ones_ovl_count", int'(cnt_a[2]), 3);
    chk("ones_novl_y", int'(ym3), 6'b001000);
    chk("ones_novl_count", int'(cnt_a[3]), 1);
    chk("ones_novl_state", int'(st_a[3]), 2);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b0, g[0]);
      chk("gap_state", int'(st_a[0]), 2);
      chk("gap_y", int'(yv[0]), 0);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("gap_final_y", int'(yv[0]), 1);
    chk("gap_count", int'(cnt_a[0]), 1);
    step(1'b0, 1'b1, 1'b0);
    p4 = 4'b1101;
    for (int m = 0; m < 5; m++) begin
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, p4[3-k]);
      chk("sat_count", int'(cnt_a[4]), m < 3 ? m + 1 : 3);
      chk("sat_flag", int'(sat_a[4]), m >= 3 ? 1 : 0);
    end
    step(1'b0, 1'b1, 1'b0);
    chk("sat_clr_count", int'(cnt_a[4]), 0);
    chk("sat_clr_flag", int'(sat_a[4]), 0);
    chk("sat_clr_state", int'(st_a[4]), 0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_vs_match_y", int'(yv[0]), 0);
    chk("clr_vs_match_count", int'(cnt_a[0]), 0);
    chk("clr_vs_match_state", int'(st_a[0]), 0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("pre_rst_state", int'(st_a[0]), 3);
    x = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("async_rst_state", int'(st_a[0]), 0);
    chk("async_rst_y", int'(y_a[0]), 0);
    #1 reset = 1'b1;
    #1;
    chk("post_rst_y", int'(y_a[0]), 0);
    @(posedge clock);
    #1;
    chk("post_rst_state", int'(st_a[0]), 1);
    chk("post_rst_count", int'(cnt_a[0]), 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
